// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with one write port, two
// combinational read ports, a load-pending scoreboard, optional write bypass,
// optional hardwired zero register and a sequenced clear engine.
module reg_file_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int WRITE_BYPASS = 0,
  parameter int ZERO_REG     = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    INADDRESS,
  input  logic             WRITE,
  input  logic             BUSYWAIT,
  input  logic [AW-1:0]    OUT1ADDRESS,
  input  logic [AW-1:0]    OUT2ADDRESS,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  input  logic             LOAD_REQ,
  input  logic [AW-1:0]    LOAD_ADDR,
  output logic             OUT1_PENDING,
  output logic             OUT2_PENDING,
  input  logic             CLEAR,
  output logic             CLEAR_BUSY
);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wr_acc;
  logic ld_acc;

  // Register 0 is excluded from writes and loads when hardwired to zero.
  assign wr_acc = WRITE && !BUSYWAIT && (state == IDLE) &&
                  !((ZERO_REG != 0) && (INADDRESS == '0));
  assign ld_acc = LOAD_REQ && (state == IDLE) &&
                  !((ZERO_REG != 0) && (LOAD_ADDR == '0));

  // Read data: zero register first, then same-cycle bypass, then storage.
  function automatic logic [WIDTH-1:0] sel_data(
    input logic [AW-1:0]    a,
    input logic [WIDTH-1:0] stored,
    input logic             wacc,
    input logic [AW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata
  );
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if ((WRITE_BYPASS != 0) && wacc && (a == waddr)) return wdata;
    return stored;
  endfunction

  // Pending flag: a bypassed read only stays pending if a new load re-targets it.
  function automatic logic sel_pend(
    input logic          a_pend,
    input logic [AW-1:0] a,
    input logic          wacc,
    input logic [AW-1:0] waddr,
    input logic          lacc,
    input logic [AW-1:0] laddr
  );
    if ((ZERO_REG != 0) && (a == '0)) return 1'b0;
    if ((WRITE_BYPASS != 0) && wacc && (a == waddr)) return lacc && (laddr == a);
    return a_pend;
  endfunction

  assign OUT1 = sel_data(OUT1ADDRESS, regs[OUT1ADDRESS], wr_acc, INADDRESS, IN);
  assign OUT2 = sel_data(OUT2ADDRESS, regs[OUT2ADDRESS], wr_acc, INADDRESS, IN);
  assign OUT1_PENDING = sel_pend(pending[OUT1ADDRESS], OUT1ADDRESS, wr_acc,
                                 INADDRESS, ld_acc, LOAD_ADDR);
  assign OUT2_PENDING = sel_pend(pending[OUT2ADDRESS], OUT2ADDRESS, wr_acc,
                                 INADDRESS, ld_acc, LOAD_ADDR);

  // Storage, scoreboard and clear sequencer; reset aborts any clear or load.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      CLEAR_BUSY <= 1'b0;
      pending    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc) begin
            regs[INADDRESS]    <= IN;
            pending[INADDRESS] <= 1'b0;
          end
          // The load is applied after the write so a same-address load wins.
          if (ld_acc) pending[LOAD_ADDR] <= 1'b1;
          if (CLEAR) begin
            state      <= CLEARING;
            cnt        <= '0;
            CLEAR_BUSY <= 1'b1;
          end
        end
        CLEARING: begin
          regs[cnt]    <= '0;
          pending[cnt] <= 1'b0;
          cnt          <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state      <= IDLE;
            CLEAR_BUSY <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          CLEAR_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
